// File: rtl/anneal_pkg.sv
// Shared types and default widths for the Ising annealing run sequencer.
package anneal_pkg;

    localparam int unsigned NUM_SPIN_DEF = 256;
    localparam int unsigned CNT_W_DEF    = 16;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_CFG,
        ST_DT_START,
        ST_DT_BUSY,
        ST_DT_DRAIN,
        ST_PUSH,
        ST_WAIT_RES,
        ST_FLUSH,
        ST_DONE
    } anneal_state_e;

endpackage

// File: rtl/anneal_scheduler_if.sv
// Scheduler <-> analog_macro_wrap signal bundle.
interface anneal_scheduler_if #(
    parameter int unsigned NUM_SPIN = 256
);

    logic                wrap_cfg_en_o;
    logic                dt_cfg_en_o;
    logic                dt_cfg_idle_i;
    logic                spin_pop_valid_o;
    logic                spin_pop_ready_i;
    logic [NUM_SPIN-1:0] spin_pop_o;
    logic                spin_valid_i;
    logic                spin_ready_o;
    logic [NUM_SPIN-1:0] spin_i;

    modport master (
        output wrap_cfg_en_o,
        output dt_cfg_en_o,
        input  dt_cfg_idle_i,
        output spin_pop_valid_o,
        input  spin_pop_ready_i,
        output spin_pop_o,
        input  spin_valid_i,
        output spin_ready_o,
        input  spin_i
    );

    modport slave (
        input  wrap_cfg_en_o,
        input  dt_cfg_en_o,
        output dt_cfg_idle_i,
        input  spin_pop_valid_o,
        output spin_pop_ready_i,
        input  spin_pop_o,
        output spin_valid_i,
        input  spin_ready_o,
        output spin_i
    );

endinterface

// File: rtl/anneal_scheduler_stab.sv
// Spin stability tracker: wide equality compare, saturating
// consecutive-unchanged counter and convergence threshold flag.
module spin_stability_tracker
    import anneal_pkg::*;
#(
    parameter int unsigned NUM_SPIN = NUM_SPIN_DEF,
    parameter int unsigned CNT_W    = CNT_W_DEF
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                clear_i,
    input  logic                update_i,
    input  logic [NUM_SPIN-1:0] spin_new_i,
    input  logic [NUM_SPIN-1:0] spin_cur_i,
    input  logic [CNT_W-1:0]    thresh_i,
    output logic                hit_o
);

    logic [CNT_W-1:0] r_stable;
    logic [CNT_W-1:0] w_stable_nxt;
    logic             w_same;

    assign w_same = (spin_new_i == spin_cur_i);

    always_comb begin
        w_stable_nxt = '0;
        if (w_same) begin
            w_stable_nxt = (&r_stable) ? r_stable : r_stable + CNT_W'(1);
        end
    end

    // Flag reflects the count this result would produce, so the FSM
    // can terminate in the same cycle the result is accepted.
    assign hit_o = (thresh_i != '0) && (w_stable_nxt >= thresh_i);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_stable <= '0;
        end else if (clear_i) begin
            r_stable <= '0;
        end else if (update_i) begin
            r_stable <= w_stable_nxt;
        end
    end

endmodule

// File: rtl/anneal_scheduler.sv
// Top-level annealing run sequencer: config pulse, data-config phase,
// then push/collect spin loop until iteration limit or convergence.
module anneal_scheduler
    import anneal_pkg::*;
#(
    parameter int unsigned NUM_SPIN = NUM_SPIN_DEF,
    parameter int unsigned CNT_W    = CNT_W_DEF
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                start_i,
    input  logic                abort_i,
    input  logic                skip_dt_i,
    input  logic [CNT_W-1:0]    iter_max_i,
    input  logic [CNT_W-1:0]    stable_thresh_i,
    input  logic [NUM_SPIN-1:0] init_spin_i,
    anneal_scheduler_if.master  mac,
    output logic                busy_o,
    output logic                done_o,
    output logic                converged_o,
    output logic [CNT_W-1:0]    iter_cnt_o,
    output logic [NUM_SPIN-1:0] spin_q_o
);

    anneal_state_e r_state;
    anneal_state_e w_state_nxt;

    logic [NUM_SPIN-1:0] r_spin_q;
    logic [CNT_W-1:0]    r_iter;
    logic                r_conv;
    logic                r_skip;

    logic             w_load;
    logic             w_accept;
    logic             w_term;
    logic             w_stab_hit;
    logic             w_limit_hit;
    logic [CNT_W-1:0] w_iter_nxt;
    logic [CNT_W-1:0] w_limit;

    spin_stability_tracker #(
        .NUM_SPIN (NUM_SPIN),
        .CNT_W    (CNT_W)
    ) u_stab (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .clear_i    (w_load),
        .update_i   (w_accept),
        .spin_new_i (mac.spin_i),
        .spin_cur_i (r_spin_q),
        .thresh_i   (stable_thresh_i),
        .hit_o      (w_stab_hit)
    );

    assign w_iter_nxt  = (&r_iter) ? r_iter : r_iter + CNT_W'(1);
    assign w_limit     = (iter_max_i == '0) ? CNT_W'(1) : iter_max_i;
    assign w_limit_hit = (w_iter_nxt >= w_limit);
    assign w_term      = w_limit_hit | w_stab_hit;

    always_comb begin
        w_state_nxt          = r_state;
        w_load               = 1'b0;
        w_accept             = 1'b0;
        mac.wrap_cfg_en_o    = 1'b0;
        mac.dt_cfg_en_o      = 1'b0;
        mac.spin_pop_valid_o = 1'b0;
        mac.spin_ready_o     = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (start_i) begin
                    w_load      = 1'b1;
                    w_state_nxt = ST_CFG;
                end
            end
            ST_CFG: begin
                mac.wrap_cfg_en_o = 1'b1;
                w_state_nxt = r_skip ? ST_PUSH : ST_DT_START;
                if (abort_i) w_state_nxt = ST_IDLE;
            end
            ST_DT_START: begin
                mac.dt_cfg_en_o = 1'b1;
                w_state_nxt = abort_i ? ST_IDLE : ST_DT_BUSY;
            end
            ST_DT_BUSY: begin
                if (abort_i) w_state_nxt = ST_IDLE;
                else if (!mac.dt_cfg_idle_i) w_state_nxt = ST_DT_DRAIN;
            end
            ST_DT_DRAIN: begin
                if (abort_i) w_state_nxt = ST_IDLE;
                else if (mac.dt_cfg_idle_i) w_state_nxt = ST_PUSH;
            end
            ST_PUSH: begin
                mac.spin_pop_valid_o = 1'b1;
                if (abort_i) w_state_nxt = ST_IDLE;
                else if (mac.spin_pop_ready_i) w_state_nxt = ST_WAIT_RES;
            end
            ST_WAIT_RES: begin
                mac.spin_ready_o = 1'b1;
                // A result landing with abort is the flush beat itself.
                if (abort_i) begin
                    w_state_nxt = mac.spin_valid_i ? ST_IDLE : ST_FLUSH;
                end else if (mac.spin_valid_i) begin
                    w_accept    = 1'b1;
                    w_state_nxt = w_term ? ST_DONE : ST_PUSH;
                end
            end
            ST_FLUSH: begin
                mac.spin_ready_o = 1'b1;
                if (mac.spin_valid_i) w_state_nxt = ST_IDLE;
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state  <= ST_IDLE;
            r_spin_q <= '0;
            r_iter   <= '0;
            r_conv   <= 1'b0;
            r_skip   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_load) begin
                r_spin_q <= init_spin_i;
                r_iter   <= '0;
                r_conv   <= 1'b0;
                r_skip   <= skip_dt_i;
            end else if (w_accept) begin
                r_spin_q <= mac.spin_i;
                r_iter   <= w_iter_nxt;
                if (w_term) r_conv <= w_stab_hit;
            end
        end
    end

    assign mac.spin_pop_o = r_spin_q;
    assign busy_o         = (r_state != ST_IDLE);
    assign done_o         = (r_state == ST_DONE);
    assign converged_o    = r_conv;
    assign iter_cnt_o     = r_iter;
    assign spin_q_o       = r_spin_q;

endmodule

// File: doc/anneal_scheduler.md
Name: anneal_scheduler

Overview:
- Top-level sequencer for analog_macro_wrap during one Ising annealing run.
- Issues the config-latch pulse, then triggers and waits out the J/h/SFC data-config phase.
- Then runs the spin loop: push spin vector to macro, collect result, feed it back. Stops on iteration limit or convergence (spin vector unchanged for a programmed number of consecutive iterations).
- Sits between the system control registers and analog_macro_wrap.

Parameters:
num_spin, 256, spin vector width
counter_bitwidth, 16, width of iteration and stability counters

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
start_i  in  1  start run (sampled in IDLE only)
abort_i  in  1  abort run
skip_dt_i  in  1  skip data-config phase (sampled with start_i)
iter_max_i  in  counter_bitwidth  max iterations; 0 treated as 1
stable_thresh_i  in  counter_bitwidth  consecutive unchanged iterations for convergence; 0 disables convergence
init_spin_i  in  num_spin  initial spin vector (sampled with start_i)
wrap_cfg_en_o  out  1  to analog_wrap_configure_enable_i
dt_cfg_en_o  out  1  to dt_cfg_enable_i
dt_cfg_idle_i  in  1  from dt_cfg_idle_o
spin_pop_valid_o  out  1  to spin_pop_valid_i
spin_pop_ready_i  in  1  from spin_pop_ready_o
spin_pop_o  out  num_spin  to spin_pop_i
spin_valid_i  in  1  from spin_valid_o
spin_ready_o  out  1  to spin_ready_i
spin_i  in  num_spin  from spin_o
busy_o  out  1  state != IDLE
done_o  out  1  one-cycle completion pulse
converged_o  out  1  last run ended by convergence
iter_cnt_o  out  counter_bitwidth  completed iterations of current/last run
spin_q_o  out  num_spin  current/final spin register

Behaviour:
- Reset: all outputs 0; state IDLE; spin_q, iteration counter, stable counter cleared.
- States: IDLE, CFG, DT_START, DT_BUSY, DT_DRAIN, PUSH, WAIT_RES, FLUSH, DONE.
- IDLE:
  - On start_i, load spin_q <= init_spin_i, clear counters and converged_o, latch skip_dt_i. Go to CFG.
  - abort_i in IDLE is ignored.
- CFG: wrap_cfg_en_o=1 for exactly one cycle. Next state is DT_START, or PUSH if skip latched.
- DT_START: dt_cfg_en_o=1 for one cycle, then DT_BUSY.
- DT_BUSY: wait for dt_cfg_idle_i==0, then DT_DRAIN.
- DT_DRAIN: wait for dt_cfg_idle_i==1, then PUSH.
- PUSH:
  - spin_pop_valid_o=1, spin_pop_o=spin_q held stable until handshake (valid & ready).
  - On handshake go to WAIT_RES; valid drops the next cycle.
- WAIT_RES: spin_ready_o=1. On spin_valid_i:
  - stable counter: incremented (saturating) if spin_i==spin_q, else cleared.
  - spin_q <= spin_i.
  - iter_cnt += 1.
  - Terminate if the new iter_cnt >= max(iter_max_i,1), or if stable_thresh_i!=0 and the new stable count >= stable_thresh_i.
  - Terminate -> DONE; otherwise -> PUSH, with the next push asserted the following cycle.
- Simultaneous limit and convergence in the same iteration: converged_o=1.
- DONE: done_o=1 for one cycle, then IDLE. iter_cnt_o, spin_q_o and converged_o hold until the next start.
- abort_i (priority over all other transitions in the same cycle):
  - From CFG, DT_*, PUSH, or DONE: go to IDLE; no done_o.
  - From WAIT_RES: go to FLUSH, keeping spin_ready_o=1 until one spin_valid_i handshake (result discarded), then IDLE.
  - A valid arriving in the same cycle as abort is consumed as the flush beat, and FLUSH is skipped.
- Reset mid-run: immediate return to reset values. Downstream wrapper reset is the system's responsibility.
- Counters never wrap: iter_cnt stops at iter_max; stable counter saturates at all-ones.

Decomposition:
- anneal_pkg: state enum anneal_state_e; default widths.
- One sub-module, spin_stability_tracker: equality compare + saturating stable counter + threshold flag. Keeps the wide compare out of the FSM.

Test Plan:
- skip_dt=1, iter_max=3, stable_thresh=0, macro returns ~input each time -> 3 push/result handshakes, done_o after the 3rd result, iter_cnt_o=3, converged_o=0, spin_q_o=~init.
- skip_dt=0, dt_cfg_idle low for 10 cycles -> wrap_cfg_en_o and dt_cfg_en_o single pulses in consecutive cycles; first spin_pop_valid_o rises the cycle after idle returns high.
- iter_max=100, stable_thresh=2, macro returns a fixed pattern -> terminates with iter_cnt_o=3, converged_o=1.
- spin_pop_ready_i held low 5 cycles -> spin_pop_valid_o and spin_pop_o stable throughout, single handshake.
- abort_i in WAIT_RES, result arrives 4 cycles later -> FLUSH consumes it, IDLE, no done_o, busy_o low the cycle after the handshake.
- iter_max=0, stable_thresh=0 -> exactly one iteration, done_o pulse, iter_cnt_o=1.
